bnn_conv3x3_stream: RTL and testbench

//  Parametrised binary (XNOR/popcount) 3x3 convolution engine. Processes a list of square

---
 rtl/bnn_conv3x3_stream_if.sv | 25 ++
 rtl/bnn_conv3x3_stream.sv | 118 +++++++++++
 tb/tb_bnn_conv3x3_stream.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/bnn_conv3x3_stream_if.sv
// bnn_conv3x3_stream_if: run/busy control plus input SRAM, output SRAM and weight memory ports of the conv engine.
interface bnn_conv3x3_stream_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic              dut_run;
  logic              dut_busy;
  logic [ADDR_W-1:0] dut_sram_read_address;
  logic [DATA_W-1:0] sram_dut_read_data;
  logic [ADDR_W-1:0] dut_sram_write_address;
  logic [DATA_W-1:0] dut_sram_write_data;
  logic              dut_sram_write_enable;
  logic [ADDR_W-1:0] dut_wmem_read_address;
  logic [DATA_W-1:0] wmem_dut_read_data;
  modport master (
    input  dut_run, sram_dut_read_data, wmem_dut_read_data,
    output dut_busy, dut_sram_read_address, dut_sram_write_address,
           dut_sram_write_data, dut_sram_write_enable, dut_wmem_read_address
  );
  modport slave (
    output dut_run, sram_dut_read_data, wmem_dut_read_data,
    input  dut_busy, dut_sram_read_address, dut_sram_write_address,
           dut_sram_write_data, dut_sram_write_enable, dut_wmem_read_address
  );
endinterface

// File: rtl/bnn_conv3x3_stream.sv
// bnn_conv3x3_stream: XNOR/popcount 3x3 binary convolution over a header-delimited image list.
// Define BNN_IMG_COUNT_EN to add the img_count output (completed images in the current run).
module bnn_conv3x3_stream #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 12,
  parameter int                THRESH      = 5,
  parameter int                WEIGHT_BASE = 0,
  parameter logic [DATA_W-1:0] TERM_WORD   = 'h00FF
) (
  input  logic clk,
  input  logic reset_b,
  bnn_conv3x3_stream_if.master bus
`ifdef BNN_IMG_COUNT_EN
  ,
  output logic [7:0] img_count
`endif
);
  typedef enum logic [2:0] {IDLE, HDR, FILL, STREAM, DONE} state_t;
  state_t st, nxt;
  logic ph, busy, rv, cv, we, hok, run, unused_ok;
  logic [4:0] n, ri, rn, hn;
  logic [8:0] kern, win;
  logic [DATA_W-1:0] r0, r1, r2, wd, conv, rdata;
  logic [ADDR_W-1:0] ra, wa, wm;

  assign run = bus.dut_run;
  assign rdata = bus.sram_dut_read_data;
  assign hn = rdata[4:0];
  assign hok = rdata != TERM_WORD && hn >= 5'd3 && 32'(hn) <= DATA_W;
  assign unused_ok = &{1'b0, bus.wmem_dut_read_data[DATA_W-1:9]};
  assign bus.dut_busy = busy;
  assign bus.dut_sram_read_address = ra;
  assign bus.dut_sram_write_address = wa;
  assign bus.dut_sram_write_data = wd;
  assign bus.dut_sram_write_enable = we;
  assign bus.dut_wmem_read_address = wm;

  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) st <= IDLE;
    else st <= nxt;

  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = run ? HDR : IDLE;
      HDR:     nxt = !ph ? HDR : hok ? FILL : DONE;
      FILL:    nxt = ri != 5'd2 ? FILL : n == 5'd3 ? HDR : STREAM;
      STREAM:  nxt = ri == n - 5'd1 ? HDR : STREAM;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // r0/r1/r2 hold the three most recent rows, oldest in r0; bits beyond N-3 are masked off.
  always_comb begin
    conv = '0;
    win = '0;
    for (int j = 0; j < DATA_W - 2; j++) begin
      win = {r2[j+2 -: 3], r1[j+2 -: 3], r0[j+2 -: 3]};
      conv[j] = ($countones(~(win ^ kern)) >= THRESH) && (j <= int'(n) - 3);
    end
  end

  // Header/kernel data returns in the second HDR cycle (ph=1); rows stream one per cycle.
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      {ph, busy, rv, cv, we} <= '0;
      {n, ri, rn} <= '0;
      kern <= '0;
      {r0, r1, r2, wd} <= '0;
      {ra, wa, wm} <= '0;
    end else begin
      rv <= st == FILL || st == STREAM;
      cv <= rv && rn >= 5'd2;
      we <= cv;
      if (cv) wd <= conv;
      if (we) wa <= wa + ADDR_W'(1);
      if (rv) begin
        r0 <= r1;
        r1 <= r2;
        r2 <= rdata;
        rn <= rn + 5'd1;
      end
      if (st == IDLE && run) begin
        busy <= 1'b1;
        ra <= '0;
        wa <= '0;
        wm <= ADDR_W'(WEIGHT_BASE);
      end
      if (st == HDR) ph <= ~ph;
      if (st == HDR && ph && hok) begin
        n <= hn;
        kern <= bus.wmem_dut_read_data[8:0];
        ra <= ra + ADDR_W'(1);
        ri <= '0;
        rn <= '0;
        wm <= wm + ADDR_W'(1);
      end
      if (st == FILL || st == STREAM) begin
        ra <= ra + ADDR_W'(1);
        ri <= ri + 5'd1;
      end
      if (st == DONE) busy <= 1'b0;
    end

`ifdef BNN_IMG_COUNT_EN
  logic cl, wl;
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      {cl, wl} <= '0;
      img_count <= '0;
    end else begin
      cl <= rv && rn == n - 5'd1;
      wl <= cv && cl;
      img_count <= (st == IDLE && run) ? 8'd0 : img_count + 8'(we && wl);
    end
`endif
endmodule

// File: tb/tb_bnn_conv3x3_stream.sv
// tb_bnn_conv3x3_stream: randomized and directed runs checked against a plain-arithmetic convolution model.
module tb_bnn_conv3x3_stream;
  localparam logic [15:0] TERM = 16'h00FF;
  logic clk = 1'b0, reset_b = 1'b0;
  always #5 clk = ~clk;

  bnn_conv3x3_stream_if #(.DATA_W(16), .ADDR_W(12)) bus();
`ifdef BNN_IMG_COUNT_EN
  logic [7:0] img_count;
`endif
  bnn_conv3x3_stream dut (
    .clk(clk),
    .reset_b(reset_b),
    .bus(bus)
`ifdef BNN_IMG_COUNT_EN
    ,
    .img_count(img_count)
`endif
  );

  logic [15:0] sram [0:4095];
  logic [15:0] wmem [0:4095];
  int checks = 0, failures = 0, cyc = 0, ptr = 0, nimg_exp = 0;
  int wq_a[$], wq_d[$], wq_c[$], eq_a[$], eq_d[$];
  bit eq_f[$];
  bit seen [0:7];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.sram_dut_read_data <= sram[bus.dut_sram_read_address];
    bus.wmem_dut_read_data <= wmem[bus.dut_wmem_read_address];
  end

  always @(negedge clk) begin
    if (reset_b && bus.dut_sram_write_enable) begin
      wq_a.push_back(int'(bus.dut_sram_write_address));
      wq_d.push_back(int'(bus.dut_sram_write_data));
      wq_c.push_back(cyc);
    end
    if (bus.dut_busy && bus.dut_wmem_read_address < 12'd8) seen[bus.dut_wmem_read_address[2:0]] = 1'b1;
  end

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) begin
      sram[i] = 16'($urandom);
      wmem[i] = 16'($urandom);
    end
    ptr = 0;
  endtask

  task automatic add_img(int n, int mode, logic [8:0] w, int k);
    logic [10:0] up;
    up = 11'($urandom);
    sram[ptr] = {up, 5'(n)};
    for (int r = 0; r < n; r++)
      sram[ptr + 1 + r] = mode == 0 ? 16'($urandom) : mode == 1 ? 16'h0000 : 16'hFFFF;
    wmem[k] = {7'($urandom), w};
    ptr += n + 1;
  endtask

  // Reference: walk headers, convolve each window by counting matching kernel bits.
  task automatic build_exp();
    int p, k, n, wa, cnt, row;
    logic [15:0] h;
    logic [8:0] w;
    logic [15:0] ra, rb;
    eq_a.delete(); eq_d.delete(); eq_f.delete();
    p = 0; k = 0; wa = 0;
    forever begin
      h = sram[p];
      n = int'(h[4:0]);
      if (h == TERM || n < 3 || n > 16) break;
      w = wmem[k][8:0];
      for (int i = 0; i <= n - 3; i++) begin
        row = 0;
        for (int j = 0; j <= n - 3; j++) begin
          cnt = 0;
          for (int a = 0; a < 3; a++) begin
            ra = sram[p + 1 + i + a];
            for (int b = 0; b < 3; b++) begin
              rb = ra >> (j + b);
              cnt += int'(w[a*3 + b] == rb[0]);
            end
          end
          if (cnt >= 5) row |= 1 << j;
        end
        eq_a.push_back(wa % 4096);
        eq_d.push_back(row);
        eq_f.push_back(i == 0);
        wa++;
      end
      p += n + 1;
      k++;
    end
    nimg_exp = k;
  endtask

  task automatic do_run(bit pulse);
    int bc, t0, fall;
    build_exp();
    wq_a.delete(); wq_d.delete(); wq_c.delete();
    for (int i = 0; i < 8; i++) seen[i] = 1'b0;
    @(negedge clk) bus.dut_run = 1'b1;
    @(negedge clk) bus.dut_run = 1'b0;
    chk("busy_rise", int'(bus.dut_busy), 1);
`ifdef BNN_IMG_COUNT_EN
    chk("cnt_start", int'(img_count), 0);
`endif
    t0 = cyc; bc = 1; fall = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (pulse) bus.dut_run = (i == 0);
      if (!bus.dut_busy) begin
        fall = cyc;
        break;
      end
      bc++;
    end
    bus.dut_run = 1'b0;
    if (fall < 0) chk("busy_timeout", int'(bus.dut_busy), 0);
    chk("nwr", wq_a.size(), eq_a.size());
    for (int i = 0; i < wq_a.size() && i < eq_a.size(); i++) begin
      chk($sformatf("addr[%0d]", i), wq_a[i], eq_a[i]);
      chk($sformatf("data[%0d]", i), wq_d[i], eq_d[i]);
      if (i > 0 && !eq_f[i]) chk($sformatf("gap[%0d]", i), wq_c[i] - wq_c[i-1], 1);
    end
    if (wq_c.size() > 0) begin
      chk("first_lat", wq_c[0] - t0, 7);
      chk("busy_fall", fall - wq_c[wq_c.size()-1], 1);
    end else chk("busy_le3", int'(bc <= 3), 1);
`ifdef BNN_IMG_COUNT_EN
    repeat (2) @(negedge clk);
    chk("img_count", int'(img_count), nimg_exp);
`endif
  endtask

  task automatic outs_zero(string tag);
    chk({tag, "_busy"}, int'(bus.dut_busy), 0);
    chk({tag, "_we"}, int'(bus.dut_sram_write_enable), 0);
    chk({tag, "_wd"}, int'(bus.dut_sram_write_data), 0);
    chk({tag, "_wa"}, int'(bus.dut_sram_write_address), 0);
    chk({tag, "_ra"}, int'(bus.dut_sram_read_address), 0);
    chk({tag, "_wm"}, int'(bus.dut_wmem_read_address), 0);
  endtask

  task automatic add_term();
    logic [10:0] up;
    logic [4:0] bad;
    up = 11'($urandom);
    bad = $urandom_range(0, 1) ? 5'($urandom_range(0, 2)) : 5'($urandom_range(17, 31));
    sram[ptr] = $urandom_range(0, 1) ? TERM : {up, bad};
  endtask

  initial begin
    bus.dut_run = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    outs_zero("reset");
    reset_b = 1'b1;
    repeat (2) @(negedge clk);

    clear_mem(); sram[0] = TERM;
    do_run(1'b0);

    clear_mem(); add_img(3, 2, 9'h1FF, 0); sram[ptr] = TERM;
    do_run(1'b0);
    if (wq_d.size() > 0) chk("n3_data", wq_d[0], 16'h0001);

    clear_mem(); add_img(16, 1, 9'h000, 0); sram[ptr] = TERM;
    do_run(1'b0);
    if (wq_d.size() > 13) chk("n16_last", wq_d[13], 16'h3FFF);

    clear_mem(); add_img(10, 0, 9'h0A5, 0); add_img(12, 0, 9'h15A, 1); sram[ptr] = TERM;
    do_run(1'b0);
    chk("wmem0_seen", int'(seen[0]), 1);
    chk("wmem1_seen", int'(seen[1]), 1);

    clear_mem(); sram[0] = 16'h0002;
    do_run(1'b1);
    repeat (5) @(negedge clk);
    chk("idle_after_pulse", int'(bus.dut_busy), 0);

    clear_mem(); add_img(16, 0, 9'($urandom), 0); sram[ptr] = TERM;
    @(negedge clk) bus.dut_run = 1'b1;
    @(negedge clk) bus.dut_run = 1'b0;
    repeat (9) @(negedge clk);
    chk("stream_active", int'(bus.dut_sram_write_enable), 1);
    #2 reset_b = 1'b0;
    #1 outs_zero("midrst");
    @(negedge clk) reset_b = 1'b1;
    clear_mem(); add_img(8, 0, 9'($urandom), 0); add_img(5, 0, 9'($urandom), 1); sram[ptr] = TERM;
    do_run(1'b0);

    for (int t = 0; t < 8; t++) begin
      int ni;
      clear_mem();
      ni = $urandom_range(1, 3);
      for (int k = 0; k < ni; k++) add_img($urandom_range(3, 16), 0, 9'($urandom), k);
      add_term();
      do_run(1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
